// File: rtl/gpr_wb_scheduler_pkg.sv
// Shared definitions for the GPR writeback scheduler.
//   - Default sizing: number of requesters, data width, register address width.
//   - Requester indices (ALU, LSU, CSR) as they appear in the packed wb_* buses.
//   - Small helpers for the round-robin scan order.
package gpr_wb_scheduler_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_AW      = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

  // Position off steps after base, wrapped into 0..n-1 (base < n, off < n).
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

  // Pointer value after granting g: the requester just past the winner.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/gpr_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   clk    in   clock, state on posedge
//   rst    in   synchronous reset, active-high (pointer back to 0)
//   req    in   N request lines
//   grant  out  N grant lines, one-hot or zero, combinational from req
// The scan starts at rr_ptr and wraps; the pointer moves just past the
// winner after every grant and holds when nothing is requested.
module rr_arbiter
  import gpr_wb_scheduler_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] scan_idx;
  logic          found;

  always_comb begin
    // NOTE: every variable gets a default before the loop, otherwise the
    // no-request path would infer latches.
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int off = 0; off < N; off++) begin
      scan_idx = PW'(rr_index(int'(rr_ptr), off, N));
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is always updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process order.
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= PW'(rr_next(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/gpr_wb_scheduler.sv
// GPR writeback scheduler.
// Shares the single GPR write port among NUM_REQ writeback requesters
// (0=ALU, 1=LSU, 2=CSR) in round-robin order, registers the granted write
// one cycle ahead of the register file, and keeps a busy scoreboard of
// destination registers for RAW stalls and WAW issue blocking.
//   clk, rst           clock; synchronous active-high reset
//   wb_valid/wb_ready  per-requester handshake (ready is one-hot or zero)
//   wb_rd, wb_data     packed per-requester dest reg / data
//   gpr_wen/waddr/wdata registered write to the GPR file
//   iss_valid/iss_rd/iss_ready  decode issue of an instr writing iss_rd
//   rs1_addr/rs2_addr, rs1_busy/rs2_busy  operand hazard queries
//   flush              drops all pending scoreboard entries
//   err_spurious       sticky: writeback for a non-pending rd != 0
module gpr_wb_scheduler
  import gpr_wb_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int XLEN    = DEF_XLEN,
  parameter int AW      = DEF_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      wb_valid,
  output logic [NUM_REQ-1:0]      wb_ready,
  input  logic [NUM_REQ*AW-1:0]   wb_rd,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic                    gpr_wen,
  output logic [AW-1:0]           gpr_waddr,
  output logic [XLEN-1:0]         gpr_wdata,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic                    iss_ready,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    flush,
  output logic                    err_spurious
);

  localparam int NREG = 2 ** AW;

  logic [NUM_REQ-1:0] xfer_vec;
  logic               xfer;
  logic [AW-1:0]      sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               sel_rd_nz;
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;
  logic               iss_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wb_valid),
    .grant (wb_ready)
  );

  assign xfer_vec = wb_valid & wb_ready;
  assign xfer     = |xfer_vec;

  // Grant is one-hot, so the mux just picks the slice of the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_vec[i]) begin
        sel_rd   = wb_rd[i*AW +: AW];
        sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_rd_nz = (sel_rd != '0);

  // x0 is never tracked, so issuing to it is always accepted.
  assign iss_ready = !busy[iss_rd] || (iss_rd == '0);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  // Clear and set can only collide on different registers (a busy rd
  // blocks issue), so their order here does not matter; flush wins over both.
  always_comb begin
    busy_nxt = busy;
    if (xfer && sel_rd_nz) busy_nxt[sel_rd] = 1'b0;
    if (iss_fire)          busy_nxt[iss_rd] = 1'b1;
    if (flush)             busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: busy is a flop vector rather than a RAM, so it can and must be
      // cleared by reset to avoid phantom hazards after power-up.
      busy         <= '0;
      gpr_wen      <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      gpr_wen <= xfer && sel_rd_nz;
      if (xfer) begin
        gpr_waddr <= sel_rd;
        gpr_wdata <= sel_data;
      end
      if (xfer && sel_rd_nz && !busy[sel_rd]) err_spurious <= 1'b1;
    end
  end

  // The GPR read is combinational, so a register whose write sits in the
  // output stage must still read as busy for that one cycle.
  assign rs1_busy = busy[rs1_addr] ||
                    (gpr_wen && (gpr_waddr == rs1_addr) && (rs1_addr != '0));
  assign rs2_busy = busy[rs2_addr] ||
                    (gpr_wen && (gpr_waddr == rs2_addr) && (rs2_addr != '0));

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed bench for gpr_wb_scheduler: reset state, ALU writeback path,
// round-robin order and wrap, issue blocking, x0 writes, spurious-error
// flag, flush behaviour and reset of an in-flight write.
module tb_gpr_wb_scheduler;
  import gpr_wb_scheduler_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int XL = DEF_XLEN;
  localparam int AW = DEF_AW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    wb_valid;
  logic [NR-1:0]    wb_ready;
  logic [NR*AW-1:0] wb_rd;
  logic [NR*XL-1:0] wb_data;
  logic             gpr_wen;
  logic [AW-1:0]    gpr_waddr;
  logic [XL-1:0]    gpr_wdata;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             iss_ready;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             flush;
  logic             err_spurious;

  int total  = 0;
  int passed = 0;

  gpr_wb_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .gpr_wen      (gpr_wen),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_ready    (iss_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .flush        (flush),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int i, input logic [AW-1:0] rd, input logic [XL-1:0] data);
    wb_rd[i*AW +: AW]   = rd;
    wb_data[i*XL +: XL] = data;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // 1. reset / idle
    check("rst_wen", gpr_wen, 0);
    check("rst_waddr", gpr_waddr, 0);
    check("rst_wdata", gpr_wdata, 0);
    check("rst_ready", wb_ready, 3'b000);
    check("rst_iss_ready", iss_ready, 1);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    check("rst_err", err_spurious, 0);

    // 2. issue rd=5 then ALU writeback
    iss_valid = 1'b1; iss_rd = 5; #1;
    check("t2_iss_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0; rs1_addr = 5; #1;
    check("t2_rs1_busy_pending", rs1_busy, 1);
    check("t2_iss_blocked", iss_ready, 0);
    wb_valid = 3'b001; set_wb(REQ_ALU, 5, 32'hDEADBEEF); #1;
    check("t2_grant", wb_ready, 3'b001);
    tick();
    wb_valid = '0; #1;
    check("t2_wen", gpr_wen, 1);
    check("t2_waddr", gpr_waddr, 5);
    check("t2_wdata", gpr_wdata, 32'hDEADBEEF);
    check("t2_rs1_busy_inflight", rs1_busy, 1);
    check("t2_err", err_spurious, 0);
    tick();
    check("t2_wen_off", gpr_wen, 0);
    check("t2_waddr_hold", gpr_waddr, 5);
    check("t2_wdata_hold", gpr_wdata, 32'hDEADBEEF);
    check("t2_rs1_free", rs1_busy, 0);

    // 3. round-robin from reset (rd=0 so no scoreboard effect)
    pulse_reset();
    wb_rd = '0; wb_data = '0; wb_valid = 3'b111; #1;
    check("t3_grant0", wb_ready, 3'b001);
    tick();
    check("t3_grant1", wb_ready, 3'b010);
    tick();
    check("t3_grant2", wb_ready, 3'b100);
    tick();
    wb_valid = 3'b001; #1;
    check("t3_grant_alu", wb_ready, 3'b001);
    tick();
    wb_valid = 3'b101; #1;                      // pointer at 1: CSR first
    check("t3_wrap_csr", wb_ready, 3'b100);
    tick();
    check("t3_wrap_alu", wb_ready, 3'b001);     // pointer wrapped to 0
    check("t3_no_wen_x0", gpr_wen, 0);
    tick();
    wb_valid = '0; #1;
    check("t3_idle", wb_ready, 3'b000);

    // 4. WAW block on rd=7, cleared by an LSU writeback
    iss_valid = 1'b1; iss_rd = 7; #1;
    check("t4_iss_first", iss_ready, 1);
    tick();
    check("t4_iss_blocked", iss_ready, 0);
    wb_valid = 3'b010; set_wb(REQ_LSU, 7, 32'h0000A5A5); #1;
    check("t4_grant_lsu", wb_ready, 3'b010);
    tick();
    wb_valid = '0; #1;
    check("t4_iss_free", iss_ready, 1);
    check("t4_wen", gpr_wen, 1);
    check("t4_waddr", gpr_waddr, 7);
    tick();                                     // re-issue sets busy[7]
    iss_valid = 1'b0; rs2_addr = 7; #1;
    check("t4_rs2_busy", rs2_busy, 1);
    check("t4_err", err_spurious, 0);

    // 5. x0 transfer, then spurious writeback to rd=9
    wb_valid = 3'b001; set_wb(REQ_ALU, 0, 32'h00001234); #1;
    check("t5_grant_x0", wb_ready, 3'b001);
    tick();
    wb_valid = '0; #1;
    check("t5_x0_wen", gpr_wen, 0);
    check("t5_x0_waddr", gpr_waddr, 0);
    check("t5_x0_wdata", gpr_wdata, 32'h00001234);
    check("t5_busy7_kept", rs2_busy, 1);
    check("t5_no_err", err_spurious, 0);
    wb_valid = 3'b001; set_wb(REQ_ALU, 9, 32'h00000099);
    tick();
    wb_valid = '0; #1;
    check("t5_err_set", err_spurious, 1);
    check("t5_wen9", gpr_wen, 1);
    check("t5_waddr9", gpr_waddr, 9);
    tick();
    check("t5_err_sticky", err_spurious, 1);

    // 6. flush with a same-cycle CSR writeback and a same-cycle issue
    pulse_reset();
    iss_valid = 1'b1; iss_rd = 3;
    tick();
    iss_rd = 4;
    tick();
    iss_valid = 1'b0; rs1_addr = 3; rs2_addr = 4; #1;
    check("t6_busy3", rs1_busy, 1);
    check("t6_busy4", rs2_busy, 1);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 10;
    wb_valid = 3'b100; set_wb(REQ_CSR, 3, 32'h00C0FFEE); #1;
    check("t6_grant_csr", wb_ready, 3'b100);
    tick();
    flush = 1'b0; iss_valid = 1'b0; wb_valid = '0; #1;
    check("t6_wen", gpr_wen, 1);
    check("t6_waddr", gpr_waddr, 3);
    check("t6_wdata", gpr_wdata, 32'h00C0FFEE);
    check("t6_no_err", err_spurious, 0);
    check("t6_rs1_inflight", rs1_busy, 1);
    check("t6_busy4_flushed", rs2_busy, 0);
    rs1_addr = 10; #1;
    check("t6_issue_overridden", rs1_busy, 0);
    wb_valid = 3'b010; set_wb(REQ_LSU, 4, 32'h00000044); #1;
    check("t6_grant_lsu", wb_ready, 3'b010);
    tick();
    check("t6_err_after_flush", err_spurious, 1);
    check("t6_waddr4", gpr_waddr, 4);

    // rst while a write sits in the output stage and another is offered
    set_wb(REQ_LSU, 6, 32'h00000066);
    tick();
    check("rst_pend_wen", gpr_wen, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; wb_valid = '0; #1;
    check("rst_drop_wen", gpr_wen, 0);
    check("rst_drop_waddr", gpr_waddr, 0);
    check("rst_drop_wdata", gpr_wdata, 0);
    check("rst_clear_err", err_spurious, 0);
    check("rst_idle_ready", wb_ready, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
